// File: rtl/alu_queued.sv
// Single-cycle integer ALU whose results wait in an in-order queue until the
// CDB arbiter grants the head entry, so no result is lost when the bus is busy.
`default_nettype none

module alu_queued #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             issue_valid,
  input  logic [ROB_W-1:0] issue_rob_id,
  input  logic [4:0]       issue_op,
  input  logic [XLEN-1:0]  issue_v1,
  input  logic [XLEN-1:0]  issue_v2,
  output logic             issue_full,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic [XLEN-1:0]  cdb_value,
  input  logic             cdb_grant
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SH_W  = $clog2(XLEN);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_EQ    = 5'd10,
    OP_NE    = 5'd11,
    OP_GE    = 5'd12,
    OP_GEU   = 5'd13,
    OP_PASS2 = 5'd14
  } alu_op_e;

  alu_op_e           op;
  logic [SH_W-1:0]   shamt;
  logic              lt_s;
  logic              lt_u;
  logic [XLEN-1:0]   result;

  logic [ROB_W-1:0]  rob_mem [DEPTH];
  logic [XLEN-1:0]   val_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  assign op    = alu_op_e'(issue_op);
  assign shamt = issue_v2[SH_W-1:0];
  assign lt_s  = $signed(issue_v1) < $signed(issue_v2);
  assign lt_u  = issue_v1 < issue_v2;

  // NOTE: result gets a default before the case so every path assigns it and
  // no latch is inferred for the reserved opcodes.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = issue_v1 + issue_v2;
      OP_SUB:   result = issue_v1 - issue_v2;
      OP_AND:   result = issue_v1 & issue_v2;
      OP_OR:    result = issue_v1 | issue_v2;
      OP_XOR:   result = issue_v1 ^ issue_v2;
      OP_SLL:   result = issue_v1 << shamt;
      OP_SRL:   result = issue_v1 >> shamt;
      OP_SRA:   result = $signed(issue_v1) >>> shamt;
      OP_SLT:   result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:  result = {{(XLEN-1){1'b0}}, lt_u};
      OP_EQ:    result = {{(XLEN-1){1'b0}}, issue_v1 == issue_v2};
      OP_NE:    result = {{(XLEN-1){1'b0}}, issue_v1 != issue_v2};
      OP_GE:    result = {{(XLEN-1){1'b0}}, !lt_s};
      OP_GEU:   result = {{(XLEN-1){1'b0}}, !lt_u};
      OP_PASS2: result = issue_v2;
      default:  result = '0;
    endcase
  end

  // Full is judged on the current count alone: a same-cycle grant never frees
  // a slot for the incoming issue.
  assign issue_full = (count == CNT_W'(DEPTH));
  assign cdb_valid  = (count != '0);
  assign push       = issue_valid & ~issue_full & rdy_in & ~clear_in;
  assign pop        = cdb_valid & cdb_grant & rdy_in & ~clear_in;

  assign cdb_rob_id = cdb_valid ? rob_mem[head] : '0;
  assign cdb_value  = cdb_valid ? val_mem[head] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the head is gated by cdb_valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      rob_mem[tail] <= issue_rob_id;
      val_mem[tail] <= result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_queued.sv
// Self-checking bench for alu_queued: directed corner cases followed by
// randomized traffic, all compared against a queue-based reference model.
`timescale 1ns/1ps

module tb_alu_queued;

  localparam int XLEN  = 32;
  localparam int ROB_W = 5;
  localparam int DEPTH = 4;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             rdy_in;
  logic             clear_in;
  logic             issue_valid;
  logic [ROB_W-1:0] issue_rob_id;
  logic [4:0]       issue_op;
  logic [XLEN-1:0]  issue_v1;
  logic [XLEN-1:0]  issue_v2;
  logic             issue_full;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [XLEN-1:0]  cdb_value;
  logic             cdb_grant;

  alu_queued #(.XLEN(XLEN), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .issue_valid  (issue_valid),
    .issue_rob_id (issue_rob_id),
    .issue_op     (issue_op),
    .issue_v1     (issue_v1),
    .issue_v2     (issue_v2),
    .issue_full   (issue_full),
    .cdb_valid    (cdb_valid),
    .cdb_rob_id   (cdb_rob_id),
    .cdb_value    (cdb_value),
    .cdb_grant    (cdb_grant)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  val;
  } entry_t;

  entry_t model_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference ALU written from the operation table with plain arithmetic.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      8:  return (int'(a) <  int'(b)) ? 32'd1 : 32'd0;
      9:  return (a < b)              ? 32'd1 : 32'd0;
      10: return (a == b)             ? 32'd1 : 32'd0;
      11: return (a != b)             ? 32'd1 : 32'd0;
      12: return (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
      13: return (a >= b)             ? 32'd1 : 32'd0;
      14: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    entry_t e;
    bit     do_push;
    bit     do_pop;
    if (!rdy_in) return;
    if (clear_in) begin
      model_q.delete();
      return;
    end
    do_push = issue_valid && (model_q.size() < DEPTH);
    do_pop  = cdb_grant && (model_q.size() > 0);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      e.rob = issue_rob_id;
      e.val = ref_alu(int'(issue_op), issue_v1, issue_v2);
      model_q.push_back(e);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [ROB_W-1:0] er;
    logic [XLEN-1:0]  ev;
    er = '0;
    ev = '0;
    if (model_q.size() > 0) begin
      er = model_q[0].rob;
      ev = model_q[0].val;
    end
    check({tag, ".valid"}, 64'(cdb_valid),  64'(model_q.size() != 0));
    check({tag, ".rob"},   64'(cdb_rob_id), 64'(er));
    check({tag, ".value"}, 64'(cdb_value),  64'(ev));
    check({tag, ".full"},  64'(issue_full), 64'(model_q.size() == DEPTH));
  endtask

  // Inputs are already applied; check, take the edge, update the model.
  task automatic cycle(input string tag);
    check_outputs(tag);
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [ROB_W-1:0] rob, input logic [4:0] op,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    issue_valid  = v;
    issue_rob_id = rob;
    issue_op     = op;
    issue_v1     = a;
    issue_v2     = b;
  endtask

  task automatic single_op(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    set_issue(1'b1, 5'd9, op, a, b);
    cycle(tag);
    set_issue(1'b0, '0, '0, '0, '0);
    check({tag, ".const"}, 64'(cdb_value), 64'(exp));
    cycle(tag);
  endtask

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n_in  = 1'b0;
    rdy_in    = 1'b1;
    clear_in  = 1'b0;
    cdb_grant = 1'b0;
    set_issue(1'b0, '0, '0, '0, '0);

    // Reset state
    #12;
    check_outputs("reset");
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Single ADD with grant held high: valid for exactly one cycle
    cdb_grant = 1'b1;
    set_issue(1'b1, 5'd3, 5'd0, 32'h7FFF_FFFF, 32'h1);
    cycle("add_issue");
    set_issue(1'b0, '0, '0, '0, '0);
    check("add.valid", 64'(cdb_valid), 64'd1);
    check("add.rob",   64'(cdb_rob_id), 64'd3);
    check("add.value", 64'(cdb_value), 64'h8000_0000);
    cycle("add_out");
    check("add.gone", 64'(cdb_valid), 64'd0);

    // Shift and compare corners
    single_op("sra",  5'd7,  32'h8000_0000, 32'h21,        32'hC000_0000);
    single_op("sltu", 5'd9,  32'h1,         32'hFFFF_FFFF, 32'h1);
    single_op("slt",  5'd8,  32'h1,         32'hFFFF_FFFF, 32'h0);
    single_op("geu",  5'd13, 32'h0,         32'h0,         32'h1);
    single_op("rsvd", 5'd20, 32'h1234,      32'h5678,      32'h0);

    // Backpressure: five back-to-back issues with grant low
    cdb_grant = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_issue(1'b1, 5'(i), 5'd0, 32'(i), 32'h0);
      if (i == 5) check("bp.full_after4", 64'(issue_full), 64'd1);
      if (i < 5) cycle("bp_fill");
    end
    cdb_grant = 1'b1;
    check("bp.head1", 64'(cdb_rob_id), 64'd1);
    cycle("bp_pop1");
    check("bp.room", 64'(issue_full), 64'd0);
    check("bp.head2", 64'(cdb_rob_id), 64'd2);
    cycle("bp_pop2_push5");
    set_issue(1'b0, '0, '0, '0, '0);
    for (int i = 3; i <= 5; i++) begin
      check("bp.order", 64'(cdb_rob_id), 64'(i));
      cycle("bp_drain");
    end
    check("bp.empty", 64'(cdb_valid), 64'd0);

    // Simultaneous push/pop at count 2, then refused push at count 4
    cdb_grant = 1'b0;
    set_issue(1'b1, 5'd10, 5'd4, 32'hA, 32'h5);
    cycle("pp_fill");
    set_issue(1'b1, 5'd11, 5'd4, 32'hB, 32'h5);
    cycle("pp_fill");
    cdb_grant = 1'b1;
    set_issue(1'b1, 5'd12, 5'd4, 32'hC, 32'h5);
    cycle("pp_both");
    check("pp.head11", 64'(cdb_rob_id), 64'd11);
    cdb_grant = 1'b0;
    set_issue(1'b1, 5'd13, 5'd4, 32'hD, 32'h5);
    cycle("pp_fill");
    set_issue(1'b1, 5'd14, 5'd4, 32'hE, 32'h5);
    cycle("pp_fill");
    check("pp.full", 64'(issue_full), 64'd1);
    cdb_grant = 1'b1;
    set_issue(1'b1, 5'd15, 5'd4, 32'hF, 32'h5);
    cycle("pp_full_both");
    set_issue(1'b0, '0, '0, '0, '0);
    check("pp.count3", 64'(issue_full), 64'd0);
    for (int i = 12; i <= 14; i++) begin
      check("pp.order", 64'(cdb_rob_id), 64'(i));
      cycle("pp_drain");
    end
    check("pp.empty", 64'(cdb_valid), 64'd0);

    // Flush with a same-cycle issue
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_issue(1'b1, 5'(20 + i), 5'd1, 32'(100 + i), 32'h1);
      cycle("fl_fill");
    end
    clear_in = 1'b1;
    set_issue(1'b1, 5'd23, 5'd1, 32'h1, 32'h1);
    cdb_grant = 1'b1;
    cycle("fl_clear");
    clear_in = 1'b0;
    set_issue(1'b0, '0, '0, '0, '0);
    check("fl.valid", 64'(cdb_valid), 64'd0);
    check("fl.full",  64'(issue_full), 64'd0);

    // Stall: rdy low freezes everything
    cdb_grant = 1'b0;
    set_issue(1'b1, 5'd24, 5'd2, 32'hF0F0, 32'hFF00);
    cycle("st_fill");
    set_issue(1'b1, 5'd25, 5'd3, 32'hF0F0, 32'hFF00);
    cycle("st_fill");
    rdy_in    = 1'b0;
    cdb_grant = 1'b1;
    clear_in  = 1'b1;
    set_issue(1'b1, 5'd26, 5'd0, 32'h1, 32'h1);
    for (int i = 0; i < 3; i++) cycle("stall");
    check("st.head", 64'(cdb_rob_id), 64'd24);
    check("st.value", 64'(cdb_value), 64'h0000_F000);
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    set_issue(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 2; i++) cycle("st_drain");

    // Async reset between edges at count 3
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_issue(1'b1, 5'(27 + i), 5'd14, 32'h0, 32'(i));
      cycle("ar_fill");
    end
    set_issue(1'b0, '0, '0, '0, '0);
    check("ar.pre", 64'(cdb_valid), 64'd1);
    #2 rst_n_in = 1'b0;
    #1;
    model_q.delete();
    check("ar.valid_now", 64'(cdb_valid), 64'd0);
    check_outputs("ar_in_reset");
    #1 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    cdb_grant = 1'b1;
    set_issue(1'b1, 5'd7, 5'd4, 32'hDEAD_BEEF, 32'hFFFF_0000);
    cycle("ar_issue");
    set_issue(1'b0, '0, '0, '0, '0);
    check("ar.rob", 64'(cdb_rob_id), 64'd7);
    check("ar.value", 64'(cdb_value), 64'h2152_BEEF);
    cycle("ar_out");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      clear_in  = ($urandom_range(0, 39) == 0);
      cdb_grant = ($urandom_range(0, 9) < 6);
      set_issue($urandom_range(0, 9) < 7, 5'($urandom), 5'($urandom_range(0, 31)),
                pick_operand(), pick_operand());
      cycle("rand");
    end
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    set_issue(1'b0, '0, '0, '0, '0);
    cdb_grant = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle("final_drain");
    check("final.empty", 64'(cdb_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
